stall_control: RTL and testbench
================================

STALL_CONTROL -- requirements
Module: stall_control

Interface
REQ-001 The block SHALL have a single clock `clk`; all state SHALL update on its rising edge.
REQ-002 Reset `rst` SHALL be synchronous and active-high.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  data-hazard stall from the ID hazard detector
- flush  in  1  branch/jump resolved taken in ID
- imem_stall  in  1  instruction memory not ready this cycle
- halt_ID  in  1  HALT instruction valid in ID
- instr_IF  in  16  fetched instruction
- PC_plus2_IF  in  16  fetch PC+2
- PC_write_en  out  1  PC register load enable
- instr_ID  out  16  IF/ID instruction register
- PC_plus2_ID  out  16  IF/ID PC+2 register
- valid_ID  out  1  IF/ID contents are a real instruction
- bubble_EX  out  1  force NOP controls into ID/EX this cycle
- state  out  2  RUN=00, STALL=01, FLUSH=10, HALT=11
- stall_cycles  out  16  saturating count of data-stall cycles
- flush_count  out  16  saturating count of flushes
- stall_timeout  out  1  sticky: stall held more than 3 consecutive cycles

Function
REQ-004 NOP SHALL be encoded as 16'h0800.
REQ-005 Per-cycle action priority SHALL be: rst > HALT state > flush > stall > halt_ID > imem_stall > normal.
REQ-006 Normal: PC_write_en=1, bubble_EX=0; IF/ID SHALL load instr_IF and PC_plus2_IF with valid_ID<=1.
REQ-007 Stall: PC_write_en=0, bubble_EX=1; IF/ID and valid_ID SHALL hold; next state STALL.
REQ-008 Flush: PC_write_en=1, bubble_EX=0; IF/ID SHALL load NOP, PC_plus2_ID SHALL hold, and valid_ID<=0; next state FLUSH.
REQ-009 Simultaneous flush and stall SHALL be treated as flush; stall_cycles SHALL NOT increment that cycle.
REQ-010 imem_stall alone: PC_write_en=0, bubble_EX=0; IF/ID SHALL load NOP with valid_ID<=0; next state RUN.
REQ-011 Simultaneous stall and imem_stall SHALL be treated as stall (IF/ID holds).
REQ-012 halt_ID with neither flush nor stall: PC_write_en=0, bubble_EX=0; IF/ID SHALL load NOP with valid_ID<=0; next state HALT.
REQ-013 In HALT: PC_write_en=0, bubble_EX=1, IF/ID holds NOP with valid_ID=0, and all inputs other than rst SHALL be ignored; only rst SHALL exit HALT.
REQ-014 Next state for normal and imem_stall actions SHALL be RUN.
REQ-015 PC_write_en and bubble_EX SHALL be combinational from the current inputs and state; all other outputs SHALL be registered.
REQ-016 stall_cycles SHALL increment by 1 on each stall-action cycle and saturate at 16'hFFFF.
REQ-017 flush_count SHALL increment by 1 on each flush-action cycle and saturate at 16'hFFFF.
REQ-018 An internal 2-bit consecutive-stall counter SHALL increment on each stall-action cycle, clear on any non-stall cycle, and saturate at 3.
REQ-019 stall_timeout SHALL set when a stall-action cycle occurs while the consecutive-stall counter already equals 3, and SHALL remain set until rst.

Reset
REQ-020 On rst, outputs and state SHALL be: instr_ID=16'h0800, PC_plus2_ID=0, valid_ID=0, state=RUN, stall_cycles=0, flush_count=0, consecutive-stall counter=0, stall_timeout=0.
REQ-021 While rst is asserted, PC_write_en=0 and bubble_EX=1.
REQ-022 rst asserted mid-stall or in HALT SHALL take effect at the next edge, overriding all other inputs.

Verification
REQ-023 Two-cycle stall: instr_IF=16'h4123 loaded, then stall high for 2 cycles -> instr_ID holds 16'h4123, PC_write_en=0, bubble_EX=1 both cycles, stall_cycles=2, state=STALL.
REQ-024 Flush and stall together: instr_ID=16'h6001, flush=1 and stall=1 -> next instr_ID=16'h0800, valid_ID=0, flush_count=1, stall_cycles unchanged, PC_write_en=1.
REQ-025 HALT: halt_ID=1 in one cycle -> state=HALT; with instr_IF=16'h1234 and flush pulsed afterwards, PC_write_en stays 0 and instr_ID stays 16'h0800 until rst.
REQ-026 Timeout: stall held 4 consecutive cycles -> stall_timeout=1 after the 4th edge; stall deasserted -> stall_timeout stays 1; rst -> 0.
REQ-027 Saturation: 65536 stall cycles -> stall_cycles=16'hFFFF, with no wrap to 0.
REQ-028 imem_stall with stall: stall=1 and imem_stall=1 -> instr_ID held, bubble_EX=1; imem_stall alone -> instr_ID=16'h0800, valid_ID=0, bubble_EX=0, PC_write_en=0.

Source files
------------

// File: rtl/stall_control.sv
// IF/ID pipeline stall/flush/halt controller for a 16-bit in-order pipeline.
// Resolves the per-cycle hazard action and maintains the IF/ID register and hazard statistics.
module stall_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        imem_stall,
    input  logic        halt_ID,
    input  logic [15:0] instr_IF,
    input  logic [15:0] PC_plus2_IF,
    output logic        PC_write_en,
    output logic [15:0] instr_ID,
    output logic [15:0] PC_plus2_ID,
    output logic        valid_ID,
    output logic        bubble_EX,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        stall_timeout
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_HALTED,
        ACT_FLUSH,
        ACT_STALL,
        ACT_HALT,
        ACT_IMEM,
        ACT_NORMAL
    } action_t;

    state_t     cur_state;
    action_t    action;
    logic [1:0] consec;

    // Priority: rst > HALT state > flush > stall > halt_ID > imem_stall > normal
    always_comb begin
        action = ACT_NORMAL;
        if (rst)
            action = ACT_RESET;
        else if (cur_state == HALT)
            action = ACT_HALTED;
        else if (flush)
            action = ACT_FLUSH;
        else if (stall)
            action = ACT_STALL;
        else if (halt_ID)
            action = ACT_HALT;
        else if (imem_stall)
            action = ACT_IMEM;
    end

    always_comb begin
        PC_write_en = 1'b0;
        bubble_EX   = 1'b0;
        case (action)
            ACT_RESET:  bubble_EX   = 1'b1;
            ACT_HALTED: bubble_EX   = 1'b1;
            ACT_FLUSH:  PC_write_en = 1'b1;
            ACT_STALL:  bubble_EX   = 1'b1;
            ACT_NORMAL: PC_write_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= RUN;
            instr_ID      <= NOP;
            PC_plus2_ID   <= '0;
            valid_ID      <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
            consec        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    cur_state <= FLUSH;
                    instr_ID  <= NOP;
                    valid_ID  <= 1'b0;
                    consec    <= '0;
                    if (flush_count != '1)
                        flush_count <= flush_count + 16'd1;
                end
                ACT_STALL: begin
                    cur_state <= STALL;
                    if (stall_cycles != '1)
                        stall_cycles <= stall_cycles + 16'd1;
                    if (consec == 2'd3)
                        stall_timeout <= 1'b1;
                    else
                        consec <= consec + 2'd1;
                end
                ACT_HALT: begin
                    cur_state <= HALT;
                    instr_ID  <= NOP;
                    valid_ID  <= 1'b0;
                    consec    <= '0;
                end
                ACT_IMEM: begin
                    cur_state <= RUN;
                    instr_ID  <= NOP;
                    valid_ID  <= 1'b0;
                    consec    <= '0;
                end
                ACT_NORMAL: begin
                    cur_state   <= RUN;
                    instr_ID    <= instr_IF;
                    PC_plus2_ID <= PC_plus2_IF;
                    valid_ID    <= 1'b1;
                    consec      <= '0;
                end
                default: begin
                    // HALT freezes the pipeline; only rst leaves it
                    consec <= '0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_stall_control.sv
// Self-checking bench for stall_control: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_stall_control;

    logic        clk = 1'b0;
    logic        rst, stall, flush, imem_stall, halt_ID;
    logic [15:0] instr_IF, PC_plus2_IF;
    logic        PC_write_en, valid_ID, bubble_EX, stall_timeout;
    logic [15:0] instr_ID, PC_plus2_ID, stall_cycles, flush_count;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    // behavioural model
    int          m_state = 0;
    logic [15:0] m_instr = 16'h0800;
    logic [15:0] m_pc2   = 16'h0000;
    int          m_valid = 0;
    int          m_sc    = 0;
    int          m_fc    = 0;
    int          m_run   = 0;
    int          m_to    = 0;

    stall_control dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .imem_stall(imem_stall), .halt_ID(halt_ID),
        .instr_IF(instr_IF), .PC_plus2_IF(PC_plus2_IF),
        .PC_write_en(PC_write_en), .instr_ID(instr_ID),
        .PC_plus2_ID(PC_plus2_ID), .valid_ID(valid_ID),
        .bubble_EX(bubble_EX), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic cycle(input logic r, input logic s, input logic f, input logic im,
                         input logic h, input logic [15:0] ins, input logic [15:0] pc2);
        int exp_pc, exp_bub;
        rst = r; stall = s; flush = f; imem_stall = im; halt_ID = h;
        instr_IF = ins; PC_plus2_IF = pc2;
        #1;
        if (r)                 begin exp_pc = 0; exp_bub = 1; end
        else if (m_state == 3) begin exp_pc = 0; exp_bub = 1; end
        else if (f)            begin exp_pc = 1; exp_bub = 0; end
        else if (s)            begin exp_pc = 0; exp_bub = 1; end
        else if (h || im)      begin exp_pc = 0; exp_bub = 0; end
        else                   begin exp_pc = 1; exp_bub = 0; end
        chk("PC_write_en", 32'(PC_write_en), 32'(exp_pc));
        chk("bubble_EX", 32'(bubble_EX), 32'(exp_bub));
        @(posedge clk);
        if (r) begin
            m_state = 0; m_instr = 16'h0800; m_pc2 = 16'h0000; m_valid = 0;
            m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
        end else if (m_state == 3) begin
            m_run = 0;
        end else if (f) begin
            m_state = 2; m_instr = 16'h0800; m_valid = 0; m_fc = sat_inc(m_fc); m_run = 0;
        end else if (s) begin
            m_state = 1; m_sc = sat_inc(m_sc);
            if (m_run >= 3) m_to = 1;
            m_run = (m_run >= 3) ? 3 : m_run + 1;
        end else if (h) begin
            m_state = 3; m_instr = 16'h0800; m_valid = 0; m_run = 0;
        end else if (im) begin
            m_state = 0; m_instr = 16'h0800; m_valid = 0; m_run = 0;
        end else begin
            m_state = 0; m_instr = ins; m_pc2 = pc2; m_valid = 1; m_run = 0;
        end
        #1;
        chk("instr_ID", 32'(instr_ID), 32'(m_instr));
        chk("PC_plus2_ID", 32'(PC_plus2_ID), 32'(m_pc2));
        chk("valid_ID", 32'(valid_ID), 32'(m_valid));
        chk("state", 32'(state), 32'(m_state));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("flush_count", 32'(flush_count), 32'(m_fc));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_stall = 1'b0; halt_ID = 1'b0;
        instr_IF = '0; PC_plus2_IF = '0;
        @(posedge clk); #1;

        // reset state
        cycle(1, 0, 0, 0, 0, 16'hAAAA, 16'h5555);
        cycle(1, 1, 1, 1, 1, 16'hBBBB, 16'h6666);
        chk("rst_instr", 32'(instr_ID), 32'h0800);
        chk("rst_pc2", 32'(PC_plus2_ID), 32'h0);
        chk("rst_state", 32'(state), 32'h0);

        // two-cycle stall holds IF/ID
        cycle(0, 0, 0, 0, 0, 16'h4123, 16'h0010);
        cycle(0, 1, 0, 0, 0, 16'h9999, 16'h0012);
        chk("stall1_pc", 32'(PC_write_en), 32'h0);
        cycle(0, 1, 0, 0, 0, 16'h9998, 16'h0014);
        chk("stall2_instr", 32'(instr_ID), 32'h4123);
        chk("stall2_cycles", 32'(stall_cycles), 32'd2);
        chk("stall2_state", 32'(state), 32'd1);

        // flush wins over stall
        cycle(0, 0, 0, 0, 0, 16'h6001, 16'h0020);
        cycle(0, 1, 1, 0, 0, 16'h7000, 16'h0022);
        chk("flush_instr", 32'(instr_ID), 32'h0800);
        chk("flush_valid", 32'(valid_ID), 32'h0);
        chk("flush_count", 32'(flush_count), 32'd1);
        chk("flush_sc_unchanged", 32'(stall_cycles), 32'd2);
        chk("flush_pc2_held", 32'(PC_plus2_ID), 32'h0020);

        // stall beats imem_stall; imem_stall alone inserts NOP
        cycle(0, 0, 0, 0, 0, 16'h7777, 16'h0030);
        cycle(0, 1, 0, 1, 0, 16'h1111, 16'h0032);
        chk("st_im_instr", 32'(instr_ID), 32'h7777);
        cycle(0, 0, 0, 1, 0, 16'h2222, 16'h0034);
        chk("im_instr", 32'(instr_ID), 32'h0800);
        chk("im_valid", 32'(valid_ID), 32'h0);
        chk("im_state", 32'(state), 32'h0);

        // timeout after the 4th consecutive stall, sticky until rst
        cycle(1, 0, 0, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 0, 0, 0, 16'h3456, 16'h0040);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("to_after3", 32'(stall_timeout), 32'h0);
        cycle(0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("to_after4", 32'(stall_timeout), 32'h1);
        cycle(0, 0, 0, 0, 0, 16'h5678, 16'h0042);
        chk("to_sticky", 32'(stall_timeout), 32'h1);
        cycle(1, 0, 0, 0, 0, 16'h0, 16'h0);
        chk("to_cleared", 32'(stall_timeout), 32'h0);

        // HALT ignores everything but rst
        cycle(0, 0, 0, 0, 0, 16'h4444, 16'h0050);
        cycle(0, 0, 0, 0, 1, 16'h0, 16'h0052);
        chk("halt_state", 32'(state), 32'h3);
        cycle(0, 0, 1, 0, 0, 16'h1234, 16'h0054);
        cycle(0, 1, 0, 1, 1, 16'h1234, 16'h0056);
        cycle(0, 0, 0, 0, 0, 16'h1234, 16'h0058);
        chk("halt_instr", 32'(instr_ID), 32'h0800);
        chk("halt_fc", 32'(flush_count), 32'h0);
        cycle(1, 0, 0, 0, 0, 16'h0, 16'h0);
        chk("halt_exit", 32'(state), 32'h0);

        // stall_cycles saturation
        for (int i = 0; i < 65536; i++) cycle(0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("sat_ffff", 32'(stall_cycles), 32'hFFFF);
        cycle(0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("sat_nowrap", 32'(stall_cycles), 32'hFFFF);
        cycle(1, 0, 0, 0, 0, 16'h0, 16'h0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 29) == 0),
                  16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
